// File: rtl/uart_pkg.sv
// Shared types and constants for the counter UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FRAME_BITS = UART_DATA_W + 2;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int baud_cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: pulses tick on the last cycle of every CLKS_PER_BIT-cycle slot.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int                CNT_W   = baud_cnt_w(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = !clear && (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/count_uart_tx.sv
// Serialises one accepted byte per 8N1 frame onto a registered, idle-high tx line.
module count_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_W       = UART_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx,
    output logic              busy
);

    localparam int               BIT_W    = baud_cnt_w(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    uart_state_e       state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              tx_q, tx_d;
    logic              tick;

    // Holding the timer cleared in IDLE means every bit slot starts at count 0;
    // all other state changes happen on tick, where the timer wraps anyway.
    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(state_q == IDLE),
        .tick (tick)
    );

    assign in_ready = (state_q == IDLE);
    assign busy     = !in_ready;
    assign tx       = tx_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d = in_data;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_BIT) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // tx is registered from the next state so the line level lines up with the state.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: doc/count_uart_tx.md
Name: count_uart_tx

Overview:
Downstream stage of the 8-bit demo counter: takes a counter byte over a valid/ready handshake and serialises it as one 8N1 UART frame on a single pin.
- Sits between the counter output (uo_out value) and a spare IO pin, so the count can be logged by a host serial terminal.
- One frame in flight at a time; the upstream stage stalls via in_ready.

Parameters:
CLKS_PER_BIT, 10, clock cycles per UART bit (legal range >= 2; 10 MHz clk at 10 gives 1 Mbaud)
DATA_W, 8, payload bits per frame (fixed at 8 for this design; parameterised only for the bench)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream has a byte to send
in_data  input  DATA_W  byte to send; sampled only on accept
in_ready  output  1  block can accept a byte this cycle
tx  output  1  UART line, idle high
busy  output  1  frame in progress (complement of in_ready)

Behaviour:
- Reset: state IDLE, tx=1, busy=0, in_ready=1, baud and bit counters 0, shift register 0. Reset asserted mid-frame abandons the frame; tx=1 from the next edge.
- in_ready = (state == IDLE), derived from registered state only, with no combinational path from in_valid.
- Accept happens when in_valid && in_ready are both high at a rising edge. At that edge:
  - latch in_data;
  - move to START.
- The start bit begins on the cycle after accept.
- FSM: IDLE -> START -> DATA -> STOP -> IDLE. Each of START, DATA-bit and STOP lasts exactly CLKS_PER_BIT cycles.
  - START: tx=0.
  - DATA: tx = shift[0], LSB first. Shift right at the end of each bit. Bit counter 0..DATA_W-1; leave DATA after bit DATA_W-1.
  - STOP: tx=1. After CLKS_PER_BIT cycles, return to IDLE.
- Frame length: (DATA_W+2)*CLKS_PER_BIT cycles from the start-bit edge to the end of the stop bit.
- Back-to-back frames (in_valid held high):
  - there is one IDLE cycle between frames, so the line is high for CLKS_PER_BIT+1 cycles between frames;
  - consecutive start-bit falling edges are (DATA_W+2)*CLKS_PER_BIT+1 cycles apart.
- in_valid/in_data changes while busy are ignored. They are not queued.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. Its width is clog2(CLKS_PER_BIT), minimum 1. It resets to 0 on every state change.
- tx is a registered output: no glitches, changes only on clk edges.
- busy and in_ready are never both high or both low.

Decomposition:
- Package uart_pkg:
  - state typedef (IDLE, START, DATA, STOP);
  - UART_FRAME_BITS = DATA_W+2 constant;
  - function for baud counter width.
- One sub-module, uart_baud_gen:
  - inputs: clk, rst, clear;
  - output: tick, a one-cycle pulse every CLKS_PER_BIT cycles;
  - clear restarts the count.
- The FSM and shift register stay in count_uart_tx.

Test Plan:
1. Reset values (CLKS_PER_BIT=4): hold rst 3 cycles, then release -> tx=1, busy=0, in_ready=1; tx stays 1 for 20 idle cycles.
2. Single frame: in_valid pulse with in_data=0xA5 -> in_ready low the next cycle. tx, in 4-cycle slots: 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop). busy high for 40 cycles, then in_ready=1.
3. Back-to-back: in_valid held high with 0x00, then 0xFF -> start edges 41 cycles apart. Frame 1 data all 0, frame 2 data all 1. Exactly one extra idle-high cycle between the stop bit and the next start bit.
4. Ignore-while-busy: accept 0x3C, then change in_data to 0xC3 with in_valid high during bit 3 -> 0x3C is transmitted intact. 0xC3 is sent only as the following frame, after IDLE.
5. Reset mid-frame: assert rst during data bit 4 of 0x5A -> tx=1 and in_ready=1 on the next edge. No further low bits appear. A new 0x81 frame after release is clean.
6. Counter integration: drive in_data from an 8-bit counter enabled on accept, for 258 frames -> a bench UART receiver model decodes 0x00..0xFF, 0x00, 0x01 (wrap) with no framing errors.
